axil_cmd_master: RTL and testbench

Single-outstanding AXI4-Lite initiator that turns simple command/response handshakes into AXI-Lite write and read transactions on the PS clock domain. It drives the register bus of the PL-side register responder, letting the DMA sequencer and self-test logic read and write the same register map the PS uses. It holds at most one transaction in flight, registers the full response, and recovers from a silent slave through a cycle timeout.

---
 rtl/axil_cmd_master_if.sv | 49 ++++
 rtl/axil_cmd_master.sv | 251 +++++++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and the PL register responder.
// The master modport is the initiator side; slave is the responder side.
interface axil_cmd_master_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: turns a cmd/rsp handshake into one
// AXI-Lite write or read, with a cycle timeout that recovers from a silent slave.
module axil_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        ps_clk,
  input  logic        ps_rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wr,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  axil_cmd_master_if.master m_axi
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Abort fires on the edge where the count would reach TIMEOUT_CYCLES.
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          wr_q, wr_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_wr_q, rsp_wr_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    rsp_resp_q, rsp_resp_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic          tmo_hit;
  logic          abort;

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == LIMIT);

  always_ff @(posedge ps_clk or negedge ps_rstn) begin
    if (!ps_rstn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      wr_q          <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_wr_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      wr_q          <= wr_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_wr_q      <= rsp_wr_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    wr_d          = wr_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = 1'b0;
    rready_d      = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_wr_d      = rsp_wr_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    abort         = 1'b0;

    if (state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) begin
      cnt_d = cnt_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          wr_d    = cmd_wr;
          cnt_d   = '0;
          if (cmd_wr) begin
            state_d   = WR_REQ;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end

      WR_REQ: begin
        // AW and W complete independently; each valid falls on its own handshake.
        aw_done_d = aw_done_q | (awvalid_q & m_axi.awready);
        w_done_d  = w_done_q  | (wvalid_q  & m_axi.wready);
        awvalid_d = ~aw_done_d;
        wvalid_d  = ~w_done_d;
        if (aw_done_d && w_done_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end

      WR_RESP: begin
        if (bready_q && m_axi.bvalid) begin
          state_d       = RSP;
          rsp_valid_d   = 1'b1;
          rsp_wr_d      = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_axi.bresp;
          rsp_timeout_d = 1'b0;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end else begin
          bready_d = 1'b1;
        end
      end

      RD_REQ: begin
        if (arvalid_q && m_axi.arready) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end

      RD_RESP: begin
        if (rready_q && m_axi.rvalid) begin
          state_d       = RSP;
          rsp_valid_d   = 1'b1;
          rsp_wr_d      = 1'b0;
          rsp_rdata_d   = m_axi.rdata;
          rsp_resp_d    = m_axi.rresp;
          rsp_timeout_d = 1'b0;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end else begin
          rready_d = 1'b1;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Timeout drops every bus valid/ready at once and reports a SLVERR-style response.
    if (abort) begin
      state_d       = RSP;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      bready_d      = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_wr_d      = wr_q;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
    end

    cmd_ready_d = (state_d == IDLE);
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_wr        = rsp_wr_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: one default-timeout instance for bus behaviour
// and one TIMEOUT_CYCLES=8 instance for the abort path and its boundary.
module tb_axil_cmd_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic        cmd_valid = 1'b0, cmd_wr = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid, rsp_wr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  logic        t_cmd_valid = 1'b0, t_cmd_wr = 1'b0, t_rsp_ready = 1'b0;
  logic [31:0] t_cmd_addr = '0, t_cmd_wdata = '0;
  logic [3:0]  t_cmd_wstrb = '0;
  logic        t_cmd_ready, t_rsp_valid, t_rsp_wr, t_rsp_timeout;
  logic [31:0] t_rsp_rdata;
  logic [1:0]  t_rsp_resp;

  axil_cmd_master_if bus ();
  axil_cmd_master_if bus8 ();

  axil_cmd_master u_dut (
    .ps_clk(clk), .ps_rstn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi(bus)
  );

  axil_cmd_master #(.TIMEOUT_CYCLES(8)) u_tmo (
    .ps_clk(clk), .ps_rstn(rst_n),
    .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_wr(t_cmd_wr),
    .cmd_addr(t_cmd_addr), .cmd_wdata(t_cmd_wdata), .cmd_wstrb(t_cmd_wstrb),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_wr(t_rsp_wr),
    .rsp_rdata(t_rsp_rdata), .rsp_resp(t_rsp_resp), .rsp_timeout(t_rsp_timeout),
    .m_axi(bus8)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic accept(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb);
    cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic slaves_idle;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    bus8.awready = 0; bus8.wready = 0; bus8.bvalid = 0; bus8.bresp = 0;
    bus8.arready = 0; bus8.rvalid = 0; bus8.rdata = 0; bus8.rresp = 0;
  endtask

  task automatic test_reset;
    slaves_idle();
    tick; tick;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else passes++;
    checks++; if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0)
      $display("FAIL rst_axi_vr: got %b want 00000", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}); else passes++;
    checks++; if ({bus.awaddr, bus.wdata, rsp_rdata} !== 96'h0) $display("FAIL rst_data: got %h want 0", {bus.awaddr, bus.wdata, rsp_rdata}); else passes++;
    checks++; if ({rsp_wr, rsp_resp, rsp_timeout} !== 4'b0) $display("FAIL rst_rsp_fields: got %b want 0000", {rsp_wr, rsp_resp, rsp_timeout}); else passes++;
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL rel_no_edge_cmd_ready: got %b want 0", cmd_ready); else passes++;
    tick;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL rel_cmd_ready: got %b want 1", cmd_ready); else passes++;
    checks++; if (t_cmd_ready !== 1'b1) $display("FAIL rel_t_cmd_ready: got %b want 1", t_cmd_ready); else passes++;
  endtask

  task automatic test_zero_wait_write;
    bus.awready = 1; bus.wready = 1;
    accept(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (cmd_ready !== 1'b0) $display("FAIL zw_cmd_ready: got %b want 0", cmd_ready); else passes++;
    checks++; if ({bus.awvalid, bus.wvalid} !== 2'b11) $display("FAIL zw_valids_up: got %b want 11", {bus.awvalid, bus.wvalid}); else passes++;
    checks++; if ({bus.awaddr, bus.wdata, bus.wstrb} !== {32'h10, 32'hDEADBEEF, 4'hF})
      $display("FAIL zw_payload: got %h want %h", {bus.awaddr, bus.wdata, bus.wstrb}, {32'h10, 32'hDEADBEEF, 4'hF}); else passes++;
    checks++; if ({bus.awprot, bus.arprot} !== 6'b0) $display("FAIL zw_prot: got %b want 0", {bus.awprot, bus.arprot}); else passes++;
    bus.bvalid = 1; bus.bresp = 2'b00;
    tick;
    checks++; if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b001) $display("FAIL zw_after_hs: got %b want 001", {bus.awvalid, bus.wvalid, bus.bready}); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL zw_rsp_early: got %b want 0", rsp_valid); else passes++;
    tick;
    bus.bvalid = 0; bus.awready = 0; bus.wready = 0;
    checks++; if ({rsp_valid, rsp_wr, rsp_resp, rsp_timeout, bus.bready} !== 6'b110000)
      $display("FAIL zw_rsp: got %b want 110000", {rsp_valid, rsp_wr, rsp_resp, rsp_timeout, bus.bready}); else passes++;
    checks++; if (rsp_rdata !== 32'h0) $display("FAIL zw_rdata: got %h want 0", rsp_rdata); else passes++;
    rsp_ready = 1; tick; rsp_ready = 0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL zw_release: got %b want 01", {rsp_valid, cmd_ready}); else passes++;
  endtask

  task automatic test_split_write;
    accept(1'b1, 32'h20, 32'hCAFEF00D, 4'h3);
    bus.wready = 1; tick; bus.wready = 0;
    checks++; if ({bus.awvalid, bus.wvalid} !== 2'b10) $display("FAIL sp_w_drop: got %b want 10", {bus.awvalid, bus.wvalid}); else passes++;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if ({bus.awvalid, bus.wvalid, bus.bready, bus.awaddr} !== {3'b100, 32'h20})
        $display("FAIL sp_hold_%0d: got %h want %h", i, {bus.awvalid, bus.wvalid, bus.bready, bus.awaddr}, {3'b100, 32'h20}); else passes++;
    end
    bus.awready = 1; tick; bus.awready = 0;
    checks++; if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b001) $display("FAIL sp_both_done: got %b want 001", {bus.awvalid, bus.wvalid, bus.bready}); else passes++;
    bus.bvalid = 1; bus.bresp = 2'b10; tick; bus.bvalid = 0; bus.bresp = 2'b00;
    checks++; if ({rsp_valid, rsp_wr, rsp_resp, rsp_timeout} !== 5'b11100) $display("FAIL sp_rsp: got %b want 11100", {rsp_valid, rsp_wr, rsp_resp, rsp_timeout}); else passes++;
    rsp_ready = 1; tick; rsp_ready = 0;
  endtask

  task automatic test_read_backpressure;
    bus.rdata = 32'hFFFF0000;
    accept(1'b0, 32'h44, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus.arvalid, bus.araddr, bus.rready} !== {1'b1, 32'h44, 1'b0})
        $display("FAIL rd_ar_hold_%0d: got %h want %h", i, {bus.arvalid, bus.araddr, bus.rready}, {1'b1, 32'h44, 1'b0}); else passes++;
      tick;
    end
    bus.arready = 1; tick; bus.arready = 0;
    checks++; if ({bus.arvalid, bus.rready} !== 2'b01) $display("FAIL rd_ar_done: got %b want 01", {bus.arvalid, bus.rready}); else passes++;
    repeat (4) tick;
    checks++; if ({bus.rready, rsp_valid} !== 2'b10) $display("FAIL rd_wait_r: got %b want 10", {bus.rready, rsp_valid}); else passes++;
    bus.rvalid = 1; bus.rdata = 32'h12345678; bus.rresp = 2'b00;
    tick;
    bus.rvalid = 0; bus.rdata = 32'h0;
    checks++; if (rsp_rdata !== 32'h12345678) $display("FAIL rd_rdata: got %h want 12345678", rsp_rdata); else passes++;
    checks++; if ({rsp_valid, rsp_wr, rsp_resp, rsp_timeout, bus.rready} !== 6'b100000)
      $display("FAIL rd_rsp: got %b want 100000", {rsp_valid, rsp_wr, rsp_resp, rsp_timeout, bus.rready}); else passes++;
    rsp_ready = 1; tick; rsp_ready = 0;
  endtask

  task automatic test_back_to_back;
    // Write response held in RSP while a read command waits; then the read follows.
    bus.awready = 1; bus.wready = 1;
    accept(1'b1, 32'h30, 32'h11112222, 4'hF);
    tick;
    bus.awready = 0; bus.wready = 0;
    bus.bvalid = 1; bus.bresp = 2'b01; tick; bus.bvalid = 0;
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 32'h80;
    for (int i = 0; i < 10; i++) begin
      bus.bvalid = ~bus.bvalid; bus.bresp = 2'b11;
      tick;
      checks++; if ({rsp_valid, rsp_wr, rsp_resp, rsp_timeout, cmd_ready, bus.bready, rsp_rdata} !== {7'b1101000, 32'h0})
        $display("FAIL stall_%0d: got %h want %h", i, {rsp_valid, rsp_wr, rsp_resp, rsp_timeout, cmd_ready, bus.bready, rsp_rdata}, {7'b1101000, 32'h0}); else passes++;
    end
    bus.bvalid = 0; bus.bresp = 0;
    rsp_ready = 1; tick; rsp_ready = 0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL b2b_ready: got %b want 01", {rsp_valid, cmd_ready}); else passes++;
    tick;
    cmd_valid = 0;
    checks++; if ({cmd_ready, bus.arvalid, bus.araddr} !== {2'b01, 32'h80})
      $display("FAIL b2b_accept: got %h want %h", {cmd_ready, bus.arvalid, bus.araddr}, {2'b01, 32'h80}); else passes++;
    bus.arready = 1; tick; bus.arready = 0;
    bus.rvalid = 1; bus.rdata = 32'hA5A5C3C3; tick; bus.rvalid = 0;
    checks++; if ({rsp_valid, rsp_wr, rsp_rdata} !== {2'b10, 32'hA5A5C3C3})
      $display("FAIL b2b_rsp: got %h want %h", {rsp_valid, rsp_wr, rsp_rdata}, {2'b10, 32'hA5A5C3C3}); else passes++;
    rsp_ready = 1; tick; rsp_ready = 0;
  endtask

  task automatic test_timeout;
    t_cmd_wr = 0; t_cmd_addr = 32'h100; t_cmd_valid = 1; tick; t_cmd_valid = 0;
    for (int i = 0; i < 8; i++) begin
      checks++; if ({bus8.arvalid, t_rsp_valid} !== 2'b10) $display("FAIL tmo_wait_%0d: got %b want 10", i, {bus8.arvalid, t_rsp_valid}); else passes++;
      tick;
    end
    checks++; if ({bus8.arvalid, bus8.rready, t_rsp_valid, t_rsp_timeout, t_rsp_resp, t_rsp_wr} !== 7'b0011100)
      $display("FAIL tmo_abort: got %b want 0011100", {bus8.arvalid, bus8.rready, t_rsp_valid, t_rsp_timeout, t_rsp_resp, t_rsp_wr}); else passes++;
    checks++; if (t_rsp_rdata !== 32'h0) $display("FAIL tmo_rdata: got %h want 0", t_rsp_rdata); else passes++;
    t_rsp_ready = 1; tick; t_rsp_ready = 0;
    bus8.awready = 1; bus8.wready = 1;
    t_cmd_wr = 1; t_cmd_addr = 32'h104; t_cmd_wdata = 32'h5; t_cmd_wstrb = 4'h1; t_cmd_valid = 1; tick; t_cmd_valid = 0;
    tick;
    bus8.awready = 0; bus8.wready = 0;
    bus8.bvalid = 1; tick; bus8.bvalid = 0;
    checks++; if ({t_rsp_valid, t_rsp_wr, t_rsp_resp, t_rsp_timeout} !== 5'b11000)
      $display("FAIL tmo_next_cmd: got %b want 11000", {t_rsp_valid, t_rsp_wr, t_rsp_resp, t_rsp_timeout}); else passes++;
    t_rsp_ready = 1; tick; t_rsp_ready = 0;
  endtask

  task automatic test_timeout_boundary;
    // R handshake lands on the edge where the count reaches the limit: handshake wins.
    t_cmd_wr = 0; t_cmd_addr = 32'h108; t_cmd_valid = 1; tick; t_cmd_valid = 0;
    tick; tick;
    bus8.arready = 1; tick; bus8.arready = 0;
    repeat (4) tick;
    checks++; if ({bus8.rready, t_rsp_valid} !== 2'b10) $display("FAIL bnd_pre: got %b want 10", {bus8.rready, t_rsp_valid}); else passes++;
    bus8.rvalid = 1; bus8.rdata = 32'h0BADC0DE; tick; bus8.rvalid = 0;
    checks++; if ({t_rsp_valid, t_rsp_timeout, t_rsp_resp, t_rsp_rdata} !== {4'b1000, 32'h0BADC0DE})
      $display("FAIL bnd_hs_wins: got %h want %h", {t_rsp_valid, t_rsp_timeout, t_rsp_resp, t_rsp_rdata}, {4'b1000, 32'h0BADC0DE}); else passes++;
    t_rsp_ready = 1; tick; t_rsp_ready = 0;
  endtask

  task automatic test_reset_mid;
    bus.awready = 1; bus.wready = 1;
    accept(1'b1, 32'h50, 32'h77777777, 4'hF);
    tick;
    bus.awready = 0; bus.wready = 0;
    checks++; if (bus.bready !== 1'b1) $display("FAIL rm_in_wr_resp: got %b want 1", bus.bready); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, cmd_ready, rsp_valid} !== 7'b0)
      $display("FAIL rm_async: got %b want 0000000", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, cmd_ready, rsp_valid}); else passes++;
    bus.bvalid = 1;
    tick; tick;
    checks++; if ({bus.bready, rsp_valid, cmd_ready} !== 3'b0) $display("FAIL rm_held: got %b want 000", {bus.bready, rsp_valid, cmd_ready}); else passes++;
    rst_n = 1'b1;
    tick;
    checks++; if ({cmd_ready, rsp_valid, bus.bready} !== 3'b100) $display("FAIL rm_release: got %b want 100", {cmd_ready, rsp_valid, bus.bready}); else passes++;
    tick;
    checks++; if ({rsp_valid, bus.awvalid, bus.wvalid} !== 3'b0) $display("FAIL rm_quiet: got %b want 000", {rsp_valid, bus.awvalid, bus.wvalid}); else passes++;
    bus.bvalid = 0;
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_split_write();
    test_read_backpressure();
    test_back_to_back();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
